vec_mem_arbiter: RTL

//  Shares the single SDRAM-backed memory port between three requesters: ROM/disk loader
//  (ioctl download/erase), FDD image buffer reads, and the CPU bus.

---
 rtl/vec_mem_arbiter_if.sv | 68 ++++++
 rtl/vec_mem_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vec_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : vec_mem_arbiter_if
//  Description : Requester and memory-side bus bundle for vec_mem_arbiter.
//                The slave modport is the arbiter's view. The master modport
//                is the view of the surrounding requesters and memory block.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vec_mem_arbiter_if #(
    parameter int AW = 25
);
    // loader (ioctl download/erase)
    logic          ldr_req;
    logic          ldr_we;
    logic [AW-1:0] ldr_addr;
    logic [7:0]    ldr_din;
    logic          ldr_ack;

    // FDD image buffer (read only)
    logic          fdd_req;
    logic [AW-1:0] fdd_addr;
    logic          fdd_ack;
    logic [7:0]    fdd_dout;

    // CPU bus
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din;
    logic          cpu_ack;
    logic [7:0]    cpu_dout;

    // memory port
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic          mem_rd;
    logic          mem_we;
    logic [7:0]    mem_dout;
    logic          mem_ready;

    // timeout abort indication
    logic          err;

    modport slave (
        input  ldr_req, ldr_we, ldr_addr, ldr_din,
        output ldr_ack,
        input  fdd_req, fdd_addr,
        output fdd_ack, fdd_dout,
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        output cpu_ack, cpu_dout,
        output mem_addr, mem_din, mem_rd, mem_we,
        input  mem_dout, mem_ready,
        output err
    );

    modport master (
        output ldr_req, ldr_we, ldr_addr, ldr_din,
        input  ldr_ack,
        output fdd_req, fdd_addr,
        input  fdd_ack, fdd_dout,
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        input  cpu_ack, cpu_dout,
        input  mem_addr, mem_din, mem_rd, mem_we,
        output mem_dout, mem_ready,
        input  err
    );
endinterface
`default_nettype wire

// File: rtl/vec_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vec_mem_arbiter
//  Description : Shares one SDRAM-backed byte port between the ROM/disk
//                loader, the FDD image buffer and the CPU. One transaction
//                at a time: IDLE -> CMD -> WAIT -> RESP. Fixed priority
//                ldr > fdd > cpu, except that the CPU beats the FDD once
//                the FDD has been granted STARVE_MAX times in a row while
//                the CPU was waiting. A stalled memory is abandoned after
//                TIMEOUT wait cycles with an err pulse alongside the ack.
//  Revision    : 1.0 - initial release
// ============================================================================
module vec_mem_arbiter #(
    parameter int AW         = 25,
    parameter int TIMEOUT    = 255,
    parameter int STARVE_MAX = 2
) (
    input  wire              clk_sys,
    input  wire              reset_n,
    vec_mem_arbiter_if.slave bus
);

    // Wait counter only has to reach TIMEOUT-1, the last WAIT cycle.
    localparam int c_CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(TIMEOUT - 1);

    // Starve counter saturates at STARVE_MAX.
    localparam int c_SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_LDR  = 2'd1,
        G_FDD  = 2'd2,
        G_CPU  = 2'd3
    } grant_t;

    state_t          r_state;
    grant_t          r_gnt;
    logic            r_we;
    logic [AW-1:0]   r_mem_addr;
    logic [7:0]      r_mem_din;
    logic            r_mem_rd;
    logic            r_mem_we;
    logic [c_CW-1:0] r_cnt;
    logic [c_SW-1:0] r_starve;
    logic            r_ldr_ack;
    logic            r_fdd_ack;
    logic            r_cpu_ack;
    logic            r_err;
    logic [7:0]      r_fdd_dout;
    logic [7:0]      r_cpu_dout;

    logic            w_cpu_starved;
    grant_t          w_pick;
    logic            w_pick_we;
    logic [AW-1:0]   w_pick_addr;
    logic [7:0]      w_pick_din;
    logic [c_SW-1:0] w_starve_next;

    // Choose the next requester and its command fields; only consumed in IDLE.
    always_comb begin
        w_cpu_starved = bus.cpu_req && (r_starve == c_STARVE_MAX);
        w_pick        = G_NONE;
        w_pick_we     = 1'b0;
        w_pick_addr   = '0;
        w_pick_din    = '0;
        if (bus.ldr_req) begin
            // loader is never preempted
            w_pick      = G_LDR;
            w_pick_we   = bus.ldr_we;
            w_pick_addr = bus.ldr_addr;
            w_pick_din  = bus.ldr_din;
        end else if (bus.fdd_req && !w_cpu_starved) begin
            // FDD is read-only; write data is driven as zero
            w_pick      = G_FDD;
            w_pick_addr = bus.fdd_addr;
        end else if (bus.cpu_req) begin
            w_pick      = G_CPU;
            w_pick_we   = bus.cpu_we;
            w_pick_addr = bus.cpu_addr;
            w_pick_din  = bus.cpu_din;
        end
    end

    // Starve count after this grant: CPU grant clears it, FDD grant over a waiting CPU bumps it.
    always_comb begin
        w_starve_next = r_starve;
        if (w_pick == G_CPU) begin
            w_starve_next = '0;
        end else if ((w_pick == G_FDD) && bus.cpu_req && (r_starve != c_STARVE_MAX)) begin
            w_starve_next = r_starve + 1'b1;
        end
    end

    // Transaction sequencer with registered strobes, acks, err and read data.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_gnt      <= G_NONE;
            r_we       <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_mem_rd   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_cnt      <= '0;
            r_starve   <= '0;
            r_ldr_ack  <= 1'b0;
            r_fdd_ack  <= 1'b0;
            r_cpu_ack  <= 1'b0;
            r_err      <= 1'b0;
            r_fdd_dout <= '0;
            r_cpu_dout <= '0;
        end else begin
            // strobes, acks and err are single-cycle pulses
            r_mem_rd  <= 1'b0;
            r_mem_we  <= 1'b0;
            r_ldr_ack <= 1'b0;
            r_fdd_ack <= 1'b0;
            r_cpu_ack <= 1'b0;
            r_err     <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_pick != G_NONE) begin
                        r_gnt      <= w_pick;
                        r_we       <= w_pick_we;
                        r_mem_addr <= w_pick_addr;
                        r_mem_din  <= w_pick_din;
                        // strobe is high during the CMD cycle only
                        r_mem_rd   <= !w_pick_we;
                        r_mem_we   <= w_pick_we;
                        r_starve   <= w_starve_next;
                        r_state    <= S_CMD;
                    end
                end

                S_CMD: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    if (bus.mem_ready) begin
                        if (!r_we) begin
                            if (r_gnt == G_FDD) begin
                                r_fdd_dout <= bus.mem_dout;
                            end
                            if (r_gnt == G_CPU) begin
                                r_cpu_dout <= bus.mem_dout;
                            end
                        end
                        r_ldr_ack <= (r_gnt == G_LDR);
                        r_fdd_ack <= (r_gnt == G_FDD);
                        r_cpu_ack <= (r_gnt == G_CPU);
                        r_state   <= S_RESP;
                    end else if (r_cnt == c_CNT_LAST) begin
                        // give up: ack the requester anyway, read data left untouched
                        r_ldr_ack <= (r_gnt == G_LDR);
                        r_fdd_ack <= (r_gnt == G_FDD);
                        r_cpu_ack <= (r_gnt == G_CPU);
                        r_err     <= 1'b1;
                        r_state   <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_RESP: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_din  = r_mem_din;
    assign bus.mem_rd   = r_mem_rd;
    assign bus.mem_we   = r_mem_we;
    assign bus.ldr_ack  = r_ldr_ack;
    assign bus.fdd_ack  = r_fdd_ack;
    assign bus.cpu_ack  = r_cpu_ack;
    assign bus.fdd_dout = r_fdd_dout;
    assign bus.cpu_dout = r_cpu_dout;
    assign bus.err      = r_err;

endmodule
`default_nettype wire
